led_sequence_player: RTL and testbench

// Plays a stored color sequence on the four color LEDs. This is the output-direction

---
 rtl/genius_pkg.sv | 5 +
 rtl/phase_timer.sv | 18 +
 rtl/led_sequence_player.sv | 94 +++++++++
 tb/tb_led_sequence_player.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/genius_pkg.sv
// genius_pkg: shared color codes and player FSM states for the Genius game blocks
package genius_pkg;
  typedef enum logic [1:0] {GREEN = 2'b00, RED = 2'b01, BLUE = 2'b10, YELLOW = 2'b11} color_t;
  typedef enum logic [2:0] {IDLE, FETCH, WAIT_DATA, ON, OFF, DONE} player_state_t;
endpackage

// File: rtl/phase_timer.sv
// phase_timer: loadable down-counter that saturates at zero and flags it
module phase_timer #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] value,
  input  logic         dec,
  output logic         zero
);
  logic [W-1:0] count;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) count <= '0;
    else if (load) count <= value;
    else if (dec && count != '0) count <= count - 1'b1;
  assign zero = count == '0;
endmodule

// File: rtl/led_sequence_player.sv
// led_sequence_player: fetches each stored color, lights its LED for an on-time, blanks
// for an off-time, and pulses done once the whole sequence has been shown.
module led_sequence_player
  import genius_pkg::*;
#(
  parameter int COLOR_CODEFY_W = 2,
  parameter int ADDR_WIDTH     = 5,
  parameter int TIMER_W        = 16,
  parameter int ON_SLOW        = 50,
  parameter int OFF_SLOW       = 25,
  parameter int ON_FAST        = 20,
  parameter int OFF_FAST       = 10
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      play_start,
  input  logic [ADDR_WIDTH-1:0]     seq_len,
  input  logic                      speed,
  input  logic                      abort,
  output logic                      mem_rd_en,
  output logic [ADDR_WIDTH-1:0]     mem_rd_addr,
  input  logic [COLOR_CODEFY_W-1:0] mem_rd_data,
  output logic                      led_green,
  output logic                      led_red,
  output logic                      led_blue,
  output logic                      led_yellow,
  output logic                      busy,
  output logic                      done
);
  player_state_t state, state_nx;
  logic [ADDR_WIDTH-1:0] idx, len;
  logic spd, t_load, t_dec, t_zero, last;
  logic [TIMER_W-1:0] t_value, on_m1, off_m1;
  color_t color;
  // Phase lengths come from the speed latched at start, so mid-play changes are ignored
  assign on_m1  = spd ? TIMER_W'(ON_FAST - 1) : TIMER_W'(ON_SLOW - 1);
  assign off_m1 = spd ? TIMER_W'(OFF_FAST - 1) : TIMER_W'(OFF_SLOW - 1);
  assign last   = idx == len - ADDR_WIDTH'(1);
  phase_timer #(.W(TIMER_W)) u_timer (
    .clk(clk), .rst_n(rst_n), .load(t_load), .value(t_value), .dec(t_dec), .zero(t_zero)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      idx   <= '0;
      len   <= '0;
      spd   <= 1'b0;
      color <= GREEN;
    end else begin
      state <= state_nx;
      if (state == IDLE && play_start && !abort) begin
        len <= seq_len;
        spd <= speed;
        idx <= '0;
      end
      if (state == WAIT_DATA) color <= color_t'(mem_rd_data);
      if (state == OFF && t_zero && !last) idx <= idx + 1'b1;
    end
  always_comb begin
    state_nx = state;
    t_load   = 1'b0;
    t_dec    = 1'b0;
    t_value  = on_m1;
    case (state)
      IDLE:      if (play_start) state_nx = seq_len == '0 ? DONE : FETCH;
      FETCH:     state_nx = WAIT_DATA;
      WAIT_DATA: begin
        t_load   = 1'b1;
        state_nx = ON;
      end
      ON: begin
        t_load   = t_zero;
        t_dec    = !t_zero;
        t_value  = off_m1;
        state_nx = t_zero ? OFF : ON;
      end
      OFF: begin
        t_dec    = !t_zero;
        state_nx = !t_zero ? OFF : last ? DONE : FETCH;
      end
      DONE:      state_nx = IDLE;
      default:   state_nx = IDLE;
    endcase
    if (abort) state_nx = IDLE;
  end
  assign mem_rd_en   = state == FETCH;
  assign mem_rd_addr = idx;
  assign led_green   = state == ON && color == GREEN;
  assign led_red     = state == ON && color == RED;
  assign led_blue    = state == ON && color == BLUE;
  assign led_yellow  = state == ON && color == YELLOW;
  assign busy        = state inside {FETCH, WAIT_DATA, ON, OFF};
  assign done        = state == DONE;
endmodule

// File: tb/tb_led_sequence_player.sv
// tb_led_sequence_player: directed scenarios with cycle-exact expected LED/memory/done timing
module tb_led_sequence_player;
  localparam int AW = 5;
  logic clk = 0, rst_n = 0, play_start = 0, speed = 0, abort = 0;
  logic [AW-1:0] seq_len = '0, mem_rd_addr;
  logic [1:0] mem_rd_data = '0;
  logic mem_rd_en, led_green, led_red, led_blue, led_yellow, busy, done;
  logic [1:0] mem [0:31];
  logic [6:0] obs;
  int checks = 0, errors = 0;

  led_sequence_player #(
    .COLOR_CODEFY_W(2), .ADDR_WIDTH(AW), .TIMER_W(16),
    .ON_SLOW(4), .OFF_SLOW(2), .ON_FAST(2), .OFF_FAST(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .play_start(play_start), .seq_len(seq_len), .speed(speed),
    .abort(abort), .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
    .led_green(led_green), .led_red(led_red), .led_blue(led_blue), .led_yellow(led_yellow),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) if (mem_rd_en) mem_rd_data <= mem[mem_rd_addr];
  assign obs = {done, busy, mem_rd_en, led_yellow, led_blue, led_red, led_green};

  // Expected {done,busy,rd_en,leds} in cycle c (c>=1) of an n-color play started in cycle 0
  function automatic logic [6:0] expect_out(int c, int n, int on, int off);
    int per = 2 + on + off;
    int k = (c - 1) / per;
    int p = (c - 1) % per;
    if (k < n) return {1'b0, 1'b1, p == 0, (p >= 2 && p < 2 + on) ? 4'b0001 << mem[k] : 4'b0000};
    return {c == 1 + n * per, 6'b0};
  endfunction

  // Holds play_start for cycle 0; returns at the sample point of cycle 1
  task automatic start(input int len, input bit spd);
    @(negedge clk);
    seq_len = AW'(len);
    speed = spd;
    play_start = 1;
    @(posedge clk);
    #1 play_start = 0;
  endtask

  task automatic load_fast_mem();
    mem[0] = 2'b00; mem[1] = 2'b01; mem[2] = 2'b10; mem[3] = 2'b11;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1 checks++;
    if (obs !== 7'b0 || mem_rd_addr !== '0) begin
      errors++;
      $display("FAIL reset_state: got outs=%b addr=%0d expected outs=0 addr=0", obs, mem_rd_addr);
    end
    @(negedge clk) rst_n = 1;
  endtask

  task automatic test_fast_sequence(input bit disturb);
    load_fast_mem();
    start(4, 1);
    for (int c = 1; c <= 26; c++) begin
      if (c > 1) begin @(posedge clk); #1; end
      checks++;
      if (obs !== expect_out(c, 4, 2, 1)) begin
        errors++;
        $display("FAIL fast%0d c=%0d: got %b expected %b", disturb, c, obs, expect_out(c, 4, 2, 1));
      end
      if (mem_rd_en) begin
        checks++;
        if (mem_rd_addr !== AW'((c - 1) / 5)) begin
          errors++;
          $display("FAIL fast_addr c=%0d: got %0d expected %0d", c, mem_rd_addr, (c - 1) / 5);
        end
      end
      if (disturb) begin
        play_start = c == 5;
        seq_len = c == 5 ? '0 : AW'(4);
        speed = c < 3;
      end
    end
    play_start = 0;
  endtask

  task automatic test_zero_len();
    start(0, 0);
    for (int c = 1; c <= 4; c++) begin
      if (c > 1) begin @(posedge clk); #1; end
      checks++;
      if (obs !== expect_out(c, 0, 4, 2)) begin
        errors++;
        $display("FAIL zero_len c=%0d: got %b expected %b", c, obs, expect_out(c, 0, 4, 2));
      end
    end
  endtask

  task automatic test_slow_single();
    mem[0] = 2'b10;
    start(1, 0);
    for (int c = 1; c <= 12; c++) begin
      if (c > 1) begin @(posedge clk); #1; end
      checks++;
      if (obs !== expect_out(c, 1, 4, 2)) begin
        errors++;
        $display("FAIL slow_single c=%0d: got %b expected %b", c, obs, expect_out(c, 1, 4, 2));
      end
    end
  endtask

  task automatic test_abort();
    logic [6:0] exp_o;
    load_fast_mem();
    start(4, 1);
    for (int c = 1; c <= 30; c++) begin
      if (c > 1) begin @(posedge clk); #1; end
      exp_o = c <= 8 ? expect_out(c, 4, 2, 1) : 7'b0;
      checks++;
      if (obs !== exp_o) begin
        errors++;
        $display("FAIL abort c=%0d: got %b expected %b", c, obs, exp_o);
      end
      abort = c == 8;
    end
    @(negedge clk);
    abort = 1;
    play_start = 1;
    seq_len = AW'(4);
    @(posedge clk);
    #1 abort = 0;
    play_start = 0;
    checks++;
    if (obs !== 7'b0) begin
      errors++;
      $display("FAIL abort_priority: got %b expected 0000000", obs);
    end
    start(4, 1);
    for (int c = 1; c <= 22; c++) begin
      if (c > 1) begin @(posedge clk); #1; end
      checks++;
      if (obs !== expect_out(c, 4, 2, 1) || (mem_rd_en && mem_rd_addr !== AW'((c - 1) / 5))) begin
        errors++;
        $display("FAIL restart c=%0d: got %b addr=%0d expected %b", c, obs, mem_rd_addr, expect_out(c, 4, 2, 1));
      end
    end
  endtask

  task automatic test_mid_play_reset();
    load_fast_mem();
    start(4, 1);
    repeat (7) @(posedge clk);
    #3 rst_n = 0;
    #1 checks++;
    if (obs !== 7'b0 || mem_rd_addr !== '0) begin
      errors++;
      $display("FAIL async_reset: got outs=%b addr=%0d expected outs=0 addr=0", obs, mem_rd_addr);
    end
    @(negedge clk) rst_n = 1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1 checks++;
      if (obs !== 7'b0) begin
        errors++;
        $display("FAIL post_reset_idle c=%0d: got %b expected 0000000", c, obs);
      end
    end
    start(4, 1);
    checks++;
    if (obs !== expect_out(1, 4, 2, 1) || mem_rd_addr !== '0) begin
      errors++;
      $display("FAIL post_reset_start: got %b addr=%0d expected %b addr=0", obs, mem_rd_addr, expect_out(1, 4, 2, 1));
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 2'b00;
    test_reset();
    test_fast_sequence(0);
    test_zero_len();
    test_slow_single();
    test_abort();
    test_fast_sequence(1);
    test_mid_play_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end
endmodule
